// File: rtl/uart_pkg.sv
// uart_pkg: constants and the FSM state type shared by uart_byte_tx and uart_byte_rx.
// Holds the baud_set encodings, the bit-period divisors for a 50 MHz clock and
// a helper that chooses between the fixed divisors and a derived one.
package uart_pkg;

    localparam int CLK_FREQ_50M = 50_000_000;

    localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
    localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
    localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
    localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
    localparam logic [2:0] BAUD_SEL_115200 = 3'd4;

    localparam int RATE_9600   = 9600;
    localparam int RATE_19200  = 19200;
    localparam int RATE_38400  = 38400;
    localparam int RATE_57600  = 57600;
    localparam int RATE_115200 = 115200;

    localparam logic [12:0] DIV_9600_50M   = 13'd5208;
    localparam logic [12:0] DIV_19200_50M  = 13'd2604;
    localparam logic [12:0] DIV_38400_50M  = 13'd1302;
    localparam logic [12:0] DIV_57600_50M  = 13'd868;
    localparam logic [12:0] DIV_115200_50M = 13'd434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Bit period in clock cycles: the tabulated value at 50 MHz, otherwise derived.
    function automatic logic [12:0] bitPeriod(input int clkFreqHz, input int rate,
                                              input logic [12:0] div50M);
        if (clkFreqHz == CLK_FREQ_50M) begin
            return div50M;
        end
        return 13'(clkFreqHz / rate);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts 0..DIV-1 for the selected rate and flags the last
// cycle of each bit period. clear_i holds the count at zero so a new frame
// always starts on a fresh bit boundary.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clear_i,
    input  logic [2:0] baudSel_i,
    output logic       tick_o
);

    localparam logic [12:0] DIV_9600   = bitPeriod(CLK_FREQ_HZ, RATE_9600,   DIV_9600_50M);
    localparam logic [12:0] DIV_19200  = bitPeriod(CLK_FREQ_HZ, RATE_19200,  DIV_19200_50M);
    localparam logic [12:0] DIV_38400  = bitPeriod(CLK_FREQ_HZ, RATE_38400,  DIV_38400_50M);
    localparam logic [12:0] DIV_57600  = bitPeriod(CLK_FREQ_HZ, RATE_57600,  DIV_57600_50M);
    localparam logic [12:0] DIV_115200 = bitPeriod(CLK_FREQ_HZ, RATE_115200, DIV_115200_50M);

    logic [12:0] cnt_q;
    logic [12:0] cnt_d;
    logic [12:0] lastCnt;

    // Terminal count for the selected rate; unused encodings fall back to 115200.
    always_comb begin
        lastCnt = DIV_115200 - 13'd1;
        case (baudSel_i)
            BAUD_SEL_9600:   lastCnt = DIV_9600   - 13'd1;
            BAUD_SEL_19200:  lastCnt = DIV_19200  - 13'd1;
            BAUD_SEL_38400:  lastCnt = DIV_38400  - 13'd1;
            BAUD_SEL_57600:  lastCnt = DIV_57600  - 13'd1;
            BAUD_SEL_115200: lastCnt = DIV_115200 - 13'd1;
            default:         lastCnt = DIV_115200 - 13'd1;
        endcase
    end

    assign tick_o = (cnt_q == lastCnt);

    // Next count: wrap at the bit boundary, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + 13'd1;
        if (tick_o || clear_i) begin
            cnt_d = 13'd0;
        end
    end

    // Bit-period counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= 13'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8-bit UART transmitter, start bit, LSB-first data, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after Data[7].
// A request is accepted while idle or in the last stop-bit cycle, which lets
// frames run back to back without an idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Send_En,
    input  logic [7:0] Data,
    input  logic [2:0] baud_set,
    output logic       uart_tx,
    output logic       Tx_Done,
    output logic       Tx_Busy
);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  data_q;
    logic [7:0]  data_d;
    logic [2:0]  baudSel_q;
    logic [2:0]  baudSel_d;
    logic [2:0]  bitIdx_q;
    logic [2:0]  bitIdx_d;
    logic        txLine_q;
    logic        txLine_d;
    logic [2:0]  nextIdx;
    logic        bitTick;
    logic        accept;
    logic        cntClear;

    uart_baud_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_baud_gen (
        .clk_i    (Clk),
        .reset_i  (Reset),
        .clear_i  (cntClear),
        .baudSel_i(baudSel_q),
        .tick_o   (bitTick)
    );

    assign accept   = Send_En && ((state_q == IDLE) || ((state_q == STOP) && bitTick));
    assign cntClear = accept || (state_q == IDLE);
    assign nextIdx  = bitIdx_q + 3'd1;

    assign uart_tx = txLine_q;
    assign Tx_Done = (state_q == STOP) && bitTick;
    assign Tx_Busy = (state_q != IDLE);

    // Frame sequencing: advance one bit per tick, load the line value for the next bit.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        baudSel_d = baudSel_q;
        bitIdx_d  = bitIdx_q;
        txLine_d  = txLine_q;
        case (state_q)
            IDLE: begin
                txLine_d = 1'b1;
            end
            START: begin
                if (bitTick) begin
                    state_d  = DATA;
                    bitIdx_d = 3'd0;
                    txLine_d = data_q[0];
                end
            end
            DATA: begin
                if (bitTick) begin
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        txLine_d = ^data_q;
`else
                        state_d  = STOP;
                        txLine_d = 1'b1;
`endif
                    end else begin
                        bitIdx_d = nextIdx;
                        txLine_d = data_q[nextIdx];
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (bitTick) begin
                    state_d  = STOP;
                    txLine_d = 1'b1;
                end
`else
                state_d  = IDLE;
                txLine_d = 1'b1;
`endif
            end
            STOP: begin
                if (bitTick) begin
                    state_d  = IDLE;
                    txLine_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                txLine_d = 1'b1;
            end
        endcase
        if (accept) begin
            state_d   = START;
            data_d    = Data;
            baudSel_d = baud_set;
            bitIdx_d  = 3'd0;
            txLine_d  = 1'b0;
        end
    end

    // State, latched request and serial line registers; reset idles the line high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            data_q    <= 8'h00;
            baudSel_q <= BAUD_SEL_9600;
            bitIdx_q  <= 3'd0;
            txLine_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            baudSel_q <= baudSel_d;
            bitIdx_q  <= bitIdx_d;
            txLine_q  <= txLine_d;
        end
    end

endmodule
